// File: rtl/vga_fb_stream.sv
// ---------------------------------------------------------------------------
// vga_fb_stream
//   Framebuffer scan-out engine. Walks a whole VGA frame (visible area plus
//   blanking), issues one AXI-Lite read per visible pixel with up to
//   MAX_OUTSTANDING beats in flight, and emits an in-order pixel stream that
//   carries RGB, active-low syncs and the frame coordinates of each beat.
//
// Ports
//   axi_clk, axi_resetn      clock, asynchronous active-low reset
//   enable                   permit issuing new beats (in-flight beats drain)
//   axi_ar*                  read address channel (master side)
//   axi_r*                   read data channel (master side)
//   out_valid / out_ready    output beat handshake
//   red/green/blue           pixel colour, 0 in blanking
//   hsync/vsync              active-low syncs of the beat
//   visible                  beat lies in the visible region
//   column/row               beat position in the whole frame
//   rresp_err                sticky flag: a non-OKAY read response was seen
//
// Handshakes: every channel transfers on a cycle where valid && ready are both
// high at the rising clock edge. A source that raises valid keeps valid and
// its payload unchanged until that transfer; a sink may change ready freely.
// ---------------------------------------------------------------------------
module vga_fb_stream #(
    parameter int                        AXI_ADDR_WIDTH  = 20,
    parameter int                        AXI_DATA_WIDTH  = 16,
    parameter int                        COLOR_BITS      = 4,
    parameter int                        COORD_WIDTH     = 10,
    parameter int                        H_VISIBLE       = 640,
    parameter int                        H_FRONT         = 16,
    parameter int                        H_SYNC          = 96,
    parameter int                        H_BACK          = 48,
    parameter int                        V_VISIBLE       = 480,
    parameter int                        V_FRONT         = 10,
    parameter int                        V_SYNC          = 2,
    parameter int                        V_BACK          = 33,
    parameter logic [AXI_ADDR_WIDTH-1:0] FB_BASE         = '0,
    parameter int                        MAX_OUTSTANDING = 4
) (
    input  logic                      axi_clk,
    input  logic                      axi_resetn,
    input  logic                      enable,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLOR_BITS-1:0]     red,
    output logic [COLOR_BITS-1:0]     green,
    output logic [COLOR_BITS-1:0]     blue,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      visible,
    output logic [COORD_WIDTH-1:0]    column,
    output logic [COORD_WIDTH-1:0]    row,
    output logic                      rresp_err
);
    localparam int H_WHOLE = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_WHOLE = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int PIX_W   = 3 * COLOR_BITS;
    localparam int META_W  = 3 + 2 * COORD_WIDTH;
    localparam int PTR_W   = $clog2(MAX_OUTSTANDING);

    localparam logic [COORD_WIDTH-1:0] H_VIS_C  = COORD_WIDTH'(H_VISIBLE);
    localparam logic [COORD_WIDTH-1:0] H_LAST   = COORD_WIDTH'(H_WHOLE - 1);
    localparam logic [COORD_WIDTH-1:0] HS_BEG   = COORD_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_WIDTH-1:0] HS_END   = COORD_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_WIDTH-1:0] V_VIS_C  = COORD_WIDTH'(V_VISIBLE);
    localparam logic [COORD_WIDTH-1:0] V_LAST   = COORD_WIDTH'(V_WHOLE - 1);
    localparam logic [COORD_WIDTH-1:0] VS_BEG   = COORD_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_WIDTH-1:0] VS_END   = COORD_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_ONE = AXI_ADDR_WIDTH'(1);
    localparam logic [PTR_W-1:0]       PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]         CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]         CREDITS  = (PTR_W + 1)'(MAX_OUTSTANDING);

    // Generator position and framebuffer address of the next visible pixel.
    logic [COORD_WIDTH-1:0]    gcol, grow;
    logic [AXI_ADDR_WIDTH-1:0] addr_ptr;
    logic                      gen_visible, gen_hsync, gen_vsync;

    // Meta FIFO: one entry per issued beat; its occupancy is the credit count.
    logic [META_W-1:0] meta_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  meta_wr, meta_rd;
    logic [PTR_W:0]    meta_count;
    logic [META_W-1:0] meta_head;
    logic              head_visible;

    // Data FIFO: read data in issue order, same depth as the credit pool.
    logic [PIX_W-1:0]  data_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  data_wr, data_rd;
    logic [PTR_W:0]    data_count;
    logic [PIX_W-1:0]  data_head;

    logic [PTR_W:0]    rd_pending;   // AR transfers whose R beat has not arrived
    logic              issue, ar_fire, r_fire, pop, pop_data;

    assign gen_visible = (gcol < H_VIS_C) && (grow < V_VIS_C);
    assign gen_hsync   = !((gcol >= HS_BEG) && (gcol < HS_END));
    assign gen_vsync   = !((grow >= VS_BEG) && (grow < VS_END));

    // A pending AR blocks issue so the address register is never overwritten.
    assign issue   = enable && (meta_count < CREDITS) && !(axi_arvalid && !axi_arready);
    assign ar_fire = axi_arvalid && axi_arready;

    // Data space is guaranteed by credits, so ready only follows reset.
    assign axi_rready = axi_resetn;
    // An R beat with no read outstanding is dropped; a same-cycle AR counts.
    assign r_fire = axi_rvalid && axi_rready && ((rd_pending != '0) || ar_fire);

    assign meta_head    = meta_mem[meta_rd];
    assign head_visible = meta_head[2*COORD_WIDTH];
    assign data_head    = data_mem[data_rd];

    assign out_valid = (meta_count != '0) && (!head_visible || (data_count != '0));
    assign pop       = out_valid && out_ready;
    assign pop_data  = pop && head_visible;

    // Beat fields are forced to idle values whenever no beat is presented.
    assign hsync   = out_valid ? meta_head[2*COORD_WIDTH+2] : 1'b1;
    assign vsync   = out_valid ? meta_head[2*COORD_WIDTH+1] : 1'b1;
    assign visible = out_valid && head_visible;
    assign column  = out_valid ? meta_head[2*COORD_WIDTH-1:COORD_WIDTH] : '0;
    assign row     = out_valid ? meta_head[COORD_WIDTH-1:0] : '0;
    assign {red, green, blue} = (out_valid && head_visible) ? data_head : '0;

    always_ff @(posedge axi_clk) begin
        if (issue) meta_mem[meta_wr] <= {gen_hsync, gen_vsync, gen_visible, gcol, grow};
        if (r_fire) data_mem[data_wr] <= axi_rdata[PIX_W-1:0];
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            gcol        <= '0;
            grow        <= '0;
            addr_ptr    <= FB_BASE;
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            meta_wr     <= '0;
            meta_rd     <= '0;
            meta_count  <= '0;
            data_wr     <= '0;
            data_rd     <= '0;
            data_count  <= '0;
            rd_pending  <= '0;
            rresp_err   <= 1'b0;
        end else begin
            if (ar_fire) axi_arvalid <= 1'b0;

            if (issue) begin
                meta_wr <= meta_wr + PTR_ONE;
                if (gen_visible) begin
                    axi_arvalid <= 1'b1;
                    axi_araddr  <= addr_ptr;
                    addr_ptr    <= addr_ptr + ADDR_ONE;
                end
                if (gcol == H_LAST) begin
                    gcol <= '0;
                    if (grow == V_LAST) begin
                        grow     <= '0;
                        // Last position of a frame is blanking, so no increment races this.
                        addr_ptr <= FB_BASE;
                    end else begin
                        grow <= grow + COORD_ONE;
                    end
                end else begin
                    gcol <= gcol + COORD_ONE;
                end
            end

            if (pop)      meta_rd <= meta_rd + PTR_ONE;
            if (pop_data) data_rd <= data_rd + PTR_ONE;
            if (r_fire)   data_wr <= data_wr + PTR_ONE;

            case ({issue, pop})
                2'b10:   meta_count <= meta_count + CNT_ONE;
                2'b01:   meta_count <= meta_count - CNT_ONE;
                default: ;
            endcase

            case ({r_fire, pop_data})
                2'b10:   data_count <= data_count + CNT_ONE;
                2'b01:   data_count <= data_count - CNT_ONE;
                default: ;
            endcase

            case ({ar_fire, r_fire})
                2'b10:   rd_pending <= rd_pending + CNT_ONE;
                2'b01:   rd_pending <= rd_pending - CNT_ONE;
                default: ;
            endcase

            if (r_fire && (axi_rresp != 2'b00)) rresp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_fb_stream.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_stream
//   Small-frame bench: H 4/1/1/1 (7 columns), V 2/1/1/1 (5 rows), FB_BASE
//   0x100, four credits. The slave returns rdata = {4'hF, addr[11:0]^12'h5A3}
//   so every pixel value is traceable to its address. The expected beat
//   stream is the plain frame walk from (0,0), independent of stalls.
// ---------------------------------------------------------------------------
module tb_vga_fb_stream;
    localparam int AW     = 20;
    localparam int DW     = 16;
    localparam int CB     = 4;
    localparam int CW     = 10;
    localparam int MAXO   = 4;
    localparam int BEAT_W = 3 + 2 * CW + 3 * CB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] axi_araddr;
    logic          axi_arvalid, axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rvalid, axi_rready;
    logic          out_valid, out_ready;
    logic [CB-1:0] red, green, blue;
    logic          hsync, vsync, visible, rresp_err;
    logic [CW-1:0] column, row;

    vga_fb_stream #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .COLOR_BITS(CB), .COORD_WIDTH(CW),
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .FB_BASE(20'h100), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .axi_clk(clk), .axi_resetn(resetn), .enable(enable),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .out_valid(out_valid), .out_ready(out_ready),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
        .visible(visible), .column(column), .row(row), .rresp_err(rresp_err)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix_of(input logic [AW-1:0] a);
        return a[11:0] ^ 12'h5A3;
    endfunction

    // ---------------- scoreboard ----------------
    logic [BEAT_W-1:0] exp_q[$];

    task automatic build_exp(input int frames);
        logic          hs, vs, vis;
        logic [AW-1:0] addr;
        logic [11:0]   pix;
        for (int f = 0; f < frames; f++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 7; c++) begin
                    hs   = (c != 5);
                    vs   = (r != 3);
                    vis  = (c < 4) && (r < 2);
                    addr = AW'(32'h100 + r * 4 + c);
                    pix  = vis ? pix_of(addr) : 12'h000;
                    exp_q.push_back({hs, vs, vis, CW'(c), CW'(r), pix});
                end
    endtask

    // ---------------- slave / sink driver ----------------
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rd_t;
    rd_t pend_q[$];

    int cyc = 0;
    int beats_seen = 0, vis_beats = 0, ar_count = 0, ar_idx = 0, max_inflight = 0;
    int ar_credit = 0, rd_lat = 0;
    bit ar_stall = 0, rand_ready = 0, err_en = 0;
    logic [CW-1:0] last_col = '0, last_row = '0;

    initial begin
        rd_t               h;
        logic [BEAT_W-1:0] got;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        out_ready   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                axi_arready = 1'b0;
                axi_rvalid  = 1'b0;
                out_ready   = 1'b0;
                continue;
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                h = pend_q.pop_front();
                axi_rvalid = 1'b1;
                axi_rdata  = {4'hF, pix_of(h.addr)};
                axi_rresp  = (err_en && h.addr == 20'h105) ? 2'b10 : 2'b00;
            end else begin
                axi_rvalid = 1'b0;
                axi_rresp  = 2'b00;
            end
            axi_arready = !ar_stall || (ar_credit > 0);
            if (axi_arvalid && axi_arready) begin
                check("araddr", axi_araddr, 32'h100 + (ar_idx % 8));
                ar_idx++;
                ar_count++;
                if (ar_stall) ar_credit--;
                pend_q.push_back('{addr: axi_araddr, due: cyc + 1 + rd_lat});
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got = {hsync, vsync, visible, column, row, red, green, blue};
                if (exp_q.size() == 0) check("sb_queue_size", exp_q.size(), 1);
                else                   check("beat", got, exp_q.pop_front());
                beats_seen++;
                if (visible) vis_beats++;
                last_col = column;
                last_row = row;
            end
            if (ar_count - vis_beats > max_inflight) max_inflight = ar_count - vis_beats;
        end
    end

    // ---------------- main sequence ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        pend_q.delete();
        ar_idx = 0; ar_count = 0; beats_seen = 0; vis_beats = 0;
        build_exp(12);
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_rresp_err", rresp_err, 0);
        check("rst_visible", visible, 0);
        check("rst_coord", {column, row}, 0);
        check("rst_colour", {red, green, blue}, 0);
        resetn = 1'b1;
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (beats_seen < target && n < budget) begin
            tick();
            n++;
        end
        if (beats_seen < target) check("wait_beats", beats_seen, target);
    endtask

    initial begin
        int a, n;
        // reset state
        apply_reset();

        // full frame with zero-latency slave, wrap into the next frame
        enable = 1'b1;
        tick();
        check("rready_high", axi_rready, 1);
        wait_beats(35 + 12, 400);

        // random sink back-pressure, 3-cycle read latency
        rand_ready = 1; rd_lat = 3;
        wait_beats(beats_seen + 80, 2000);
        rand_ready = 0; rd_lat = 0;
        repeat (20) tick();

        // AR stall: address held, nothing issued past the pending read
        ar_stall = 1; ar_credit = 0;
        tick();
        n = 0;
        while (!axi_arvalid && n < 50) begin tick(); n++; end
        check("ar_wait", axi_arvalid, 1);
        a = axi_araddr;
        repeat (5) begin
            tick();
            check("ar_hold_valid", axi_arvalid, 1);
            check("ar_hold_addr", axi_araddr, a);
        end
        check("stall_out_valid", out_valid, 0);
        ar_stall = 0;
        wait_beats(beats_seen + 20, 200);

        // non-OKAY response on pixel (1,1): sticky flag, pixel still emitted
        check("rresp_err_clear", rresp_err, 0);
        err_en = 1;
        wait_beats(beats_seen + 40, 400);
        check("rresp_err_set", rresp_err, 1);
        err_en = 0;
        repeat (10) tick();
        check("rresp_err_sticky", rresp_err, 1);

        // reset mid-frame, then drop enable with (2,0) next to issue
        apply_reset();
        ar_stall = 1; ar_credit = 1;
        enable = 1'b1;
        n = 0;
        while (!(axi_arvalid && axi_araddr == 20'h101) && n < 30) begin tick(); n++; end
        check("ar_second_addr", axi_araddr, 20'h101);
        enable = 1'b0;
        ar_stall = 0;
        repeat (10) tick();
        check("en_off_ars", ar_count, 2);
        check("en_off_beats", beats_seen, 2);
        check("en_off_drained", out_valid, 0);
        enable = 1'b1;
        wait_beats(3, 50);
        check("resume_col", last_col, 2);
        check("resume_row", last_row, 0);
        wait_beats(40, 300);

        check("max_inflight_ok", (max_inflight <= MAXO), 1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
